// File: rtl/variable_pkg.sv
// rtl/variable_pkg.sv - shared constants, types and helpers for the HP/wind game-state controller
package variable_pkg;

  localparam int          HP_MAX_DEF    = 100;
  localparam logic [15:0] WIND_SEED_DEF = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    OVER = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    P1   = 2'b01,
    P2   = 2'b10,
    DRAW = 2'b11
  } winner_t;

  // One Fibonacci step of the wind LFSR (taps 15, 13, 12, 10).
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Sign/magnitude wind: "negative zero" collapses to plain zero.
  function automatic logic [2:0] wind_norm(input logic [2:0] w);
    return (w == 3'b100) ? 3'b000 : w;
  endfunction

  // Wind that results from stepping the LFSR once from l; only the low
  // three bits of the stepped value matter, so build them directly.
  function automatic logic [2:0] wind_step(input logic [15:0] l);
    return wind_norm({l[1:0], l[15] ^ l[13] ^ l[12] ^ l[10]});
  endfunction

  // Saturating HP decrement, evaluated one bit wider so it cannot wrap.
  function automatic logic [6:0] hp_sub(input logic [6:0] hp, input logic [4:0] d);
    logic [7:0] diff;
    diff = {1'b0, hp} - {3'b000, d};
    return ({1'b0, hp} > {3'b000, d}) ? diff[6:0] : 7'd0;
  endfunction

endpackage

// File: rtl/wind_lfsr.sv
// rtl/wind_lfsr.sv - 16-bit Fibonacci LFSR with synchronous seed load and single step
module wind_lfsr
  import variable_pkg::*;
#(
  parameter logic [15:0] RST_SEED = WIND_SEED_DEF
) (
  input  logic        clk60MHz,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] lfsr
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Load has priority over step; otherwise hold.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = seed;
    end else if (step) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  // LFSR register, returns to the seed on reset.
  always_ff @(posedge clk60MHz or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= RST_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/hp_wind_ctl.sv
// rtl/hp_wind_ctl.sv - player HP / wind game-state controller with per-frame display latch
module hp_wind_ctl
  import variable_pkg::*;
#(
  parameter int          HP_MAX    = HP_MAX_DEF,
  parameter logic [15:0] LFSR_SEED = WIND_SEED_DEF
) (
  input  logic       clk60MHz,
  input  logic       rst_n,
  input  logic       vblnk,
  input  logic       new_game,
  input  logic       hit_p1,
  input  logic       hit_p2,
  input  logic [4:0] dmg,
  input  logic       turn_end,
  output logic [6:0] hp_player1,
  output logic [6:0] hp_player2,
  output logic [2:0] wind,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam logic [6:0] HP_INIT = 7'(HP_MAX);

  state_t      state_q, state_d;
  logic [6:0]  hp1_q, hp1_d;
  logic [6:0]  hp2_q, hp2_d;
  logic [2:0]  wind_q, wind_d;
  logic        game_over_q, game_over_d;
  winner_t     winner_q, winner_d;
  logic        vblnk_q;
  logic        frame_start;
  logic [6:0]  hp1_disp_q;
  logic [6:0]  hp2_disp_q;
  logic [2:0]  wind_disp_q;
  logic [15:0] lfsr;
  logic        lfsr_load;
  logic        lfsr_step;
  logic        in_play;

  assign in_play   = (state_q == PLAY);
  assign lfsr_load = new_game;
  assign lfsr_step = in_play && turn_end && !new_game;

  wind_lfsr #(
    .RST_SEED (LFSR_SEED)
  ) u_wind_lfsr (
    .clk60MHz (clk60MHz),
    .rst_n    (rst_n),
    .load     (lfsr_load),
    .seed     (LFSR_SEED),
    .step     (lfsr_step),
    .lfsr     (lfsr)
  );

  // Internal game values: new_game reinitialises, hits and turn ends apply only in PLAY.
  always_comb begin
    hp1_d  = hp1_q;
    hp2_d  = hp2_q;
    wind_d = wind_q;
    if (new_game) begin
      hp1_d  = HP_INIT;
      hp2_d  = HP_INIT;
      wind_d = 3'b000;
    end else if (in_play) begin
      if (hit_p1) begin
        hp1_d = hp_sub(hp1_q, dmg);
      end
      if (hit_p2) begin
        hp2_d = hp_sub(hp2_q, dmg);
      end
      if (turn_end) begin
        wind_d = wind_step(lfsr);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk60MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a fatal hit ends the game unless new_game restarts it in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (new_game) state_d = PLAY;
      PLAY: begin
        if (new_game) begin
          state_d = PLAY;
        end else if ((hp1_d == 7'd0) || (hp2_d == 7'd0)) begin
          state_d = OVER;
        end
      end
      OVER: if (new_game) state_d = PLAY;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs, computed from the next state so the registered flags track the state register.
  always_comb begin
    game_over_d = (state_d == OVER);
    winner_d    = winner_q;
    if (new_game) begin
      winner_d = NONE;
    end else if (in_play && (state_d == OVER)) begin
      if ((hp1_d == 7'd0) && (hp2_d == 7'd0)) begin
        winner_d = DRAW;
      end else if (hp2_d == 7'd0) begin
        winner_d = P1;
      end else begin
        winner_d = P2;
      end
    end
  end

  // Internal game registers and registered FSM outputs.
  always_ff @(posedge clk60MHz or negedge rst_n) begin
    if (!rst_n) begin
      hp1_q       <= HP_INIT;
      hp2_q       <= HP_INIT;
      wind_q      <= 3'b000;
      game_over_q <= 1'b0;
      winner_q    <= NONE;
    end else begin
      hp1_q       <= hp1_d;
      hp2_q       <= hp2_d;
      wind_q      <= wind_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
    end
  end

  assign frame_start = vblnk && !vblnk_q;

  // Display latch: loads the values registered before the vblank rising edge, once per frame.
  always_ff @(posedge clk60MHz or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_q     <= 1'b0;
      hp1_disp_q  <= HP_INIT;
      hp2_disp_q  <= HP_INIT;
      wind_disp_q <= 3'b000;
    end else begin
      vblnk_q <= vblnk;
      if (frame_start) begin
        hp1_disp_q  <= hp1_q;
        hp2_disp_q  <= hp2_q;
        wind_disp_q <= wind_q;
      end
    end
  end

  assign hp_player1 = hp1_disp_q;
  assign hp_player2 = hp2_disp_q;
  assign wind       = wind_disp_q;
  assign game_over  = game_over_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_hp_wind_ctl.sv
// tb/tb_hp_wind_ctl.sv - directed self-checking bench for hp_wind_ctl
module tb_hp_wind_ctl;

  logic       clk60MHz = 1'b0;
  logic       rst_n;
  logic       vblnk;
  logic       new_game;
  logic       hit_p1;
  logic       hit_p2;
  logic [4:0] dmg;
  logic       turn_end;
  logic [6:0] hp_player1;
  logic [6:0] hp_player2;
  logic [2:0] wind;
  logic       game_over;
  logic [1:0] winner;

  int checks   = 0;
  int failures = 0;

  logic [15:0] ml;
  logic [2:0]  expw;

  hp_wind_ctl dut (
    .clk60MHz   (clk60MHz),
    .rst_n      (rst_n),
    .vblnk      (vblnk),
    .new_game   (new_game),
    .hit_p1     (hit_p1),
    .hit_p2     (hit_p2),
    .dmg        (dmg),
    .turn_end   (turn_end),
    .hp_player1 (hp_player1),
    .hp_player2 (hp_player2),
    .wind       (wind),
    .game_over  (game_over),
    .winner     (winner)
  );

  always #8 clk60MHz = ~clk60MHz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk60MHz);
  endtask

  // One-cycle pulse of the given controls, sampled by the next rising edge.
  task automatic drive(input logic ng, input logic h1, input logic h2,
                       input logic [4:0] d, input logic te);
    new_game = ng;
    hit_p1   = h1;
    hit_p2   = h2;
    dmg      = d;
    turn_end = te;
    step();
    new_game = 1'b0;
    hit_p1   = 1'b0;
    hit_p2   = 1'b0;
    dmg      = 5'd0;
    turn_end = 1'b0;
  endtask

  // Raise vblank for one edge (frame_start), then drop it again.
  task automatic frame();
    vblnk = 1'b1;
    step();
    vblnk = 1'b0;
    step();
  endtask

  initial begin
    rst_n = 1'b0; vblnk = 1'b0; new_game = 1'b0; hit_p1 = 1'b0; hit_p2 = 1'b0;
    dmg = 5'd0; turn_end = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Reset state
    chk("rst_hp1", hp_player1, 100);
    chk("rst_hp2", hp_player2, 100);
    chk("rst_wind", wind, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_winner", winner, 0);
    chk("rst_state", dut.state_q, 0);

    // Hit while IDLE is ignored
    drive(1'b0, 1'b1, 1'b0, 5'd10, 1'b0);
    chk("idle_hit_hp1_int", dut.hp1_q, 100);
    chk("idle_hit_state", dut.state_q, 0);

    // Saturation and win
    drive(1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("ng_state_play", dut.state_q, 1);
    drive(1'b0, 1'b1, 1'b0, 5'd31, 1'b0);
    chk("sat_hp1_69", dut.hp1_q, 69);
    drive(1'b0, 1'b1, 1'b0, 5'd31, 1'b0);
    chk("sat_hp1_38", dut.hp1_q, 38);
    drive(1'b0, 1'b1, 1'b0, 5'd31, 1'b0);
    chk("sat_hp1_7", dut.hp1_q, 7);
    chk("sat_not_over_yet", game_over, 0);
    drive(1'b0, 1'b1, 1'b0, 5'd31, 1'b0);
    chk("sat_hp1_0", dut.hp1_q, 0);
    chk("sat_game_over", game_over, 1);
    chk("sat_winner_p2", winner, 2);
    chk("sat_disp_before_frame", hp_player1, 100);
    frame();
    chk("sat_disp_after_frame", hp_player1, 0);
    drive(1'b0, 1'b0, 1'b1, 5'd10, 1'b0);
    chk("over_hit_ignored", dut.hp2_q, 100);

    // Draw
    drive(1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("draw_restart_game_over", game_over, 0);
    chk("draw_restart_winner", winner, 0);
    repeat (3) drive(1'b0, 1'b1, 1'b1, 5'd31, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 5'd2, 1'b0);
    chk("draw_hp1_5", dut.hp1_q, 5);
    chk("draw_hp2_5", dut.hp2_q, 5);
    drive(1'b0, 1'b1, 1'b1, 5'd0, 1'b0);
    chk("dmg0_hp1", dut.hp1_q, 5);
    chk("dmg0_state", dut.state_q, 1);
    drive(1'b0, 1'b1, 1'b1, 5'd20, 1'b0);
    chk("draw_hp1_0", dut.hp1_q, 0);
    chk("draw_hp2_0", dut.hp2_q, 0);
    chk("draw_game_over", game_over, 1);
    chk("draw_winner", winner, 3);

    // Wind
    drive(1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("wind_after_ng", dut.wind_q, 0);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    chk("wind_lfsr_first", dut.lfsr, 16'h59C3);
    chk("wind_int_first", dut.wind_q, 3'b011);
    chk("wind_disp_before_frame", wind, 0);
    frame();
    chk("wind_disp_after_frame", wind, 3'b011);
    chk("hp_disp_after_ng_frame", hp_player1, 100);
    ml = 16'h59C3;
    for (int i = 0; i < 199; i++) begin
      ml = {ml[14:0], ml[15] ^ ml[13] ^ ml[12] ^ ml[10]};
      expw = (ml[2:0] == 3'b100) ? 3'b000 : ml[2:0];
      drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
      chk("wind_turn", dut.wind_q, expw);
    end
    chk("wind_lfsr_after_200", dut.lfsr, ml);

    // Frame latch timing
    drive(1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    step();
    hit_p2 = 1'b1; dmg = 5'd10;
    step();
    hit_p2 = 1'b1; dmg = 5'd7; vblnk = 1'b1;
    step();
    hit_p2 = 1'b0; dmg = 5'd0;
    chk("fl_disp_first_hit", hp_player2, 90);
    chk("fl_int_second_hit", dut.hp2_q, 83);
    step();
    step();
    chk("fl_disp_hold", hp_player2, 90);
    vblnk = 1'b0;
    step();
    frame();
    chk("fl_disp_next_frame", hp_player2, 83);

    // Restart discards simultaneous hit and turn end
    drive(1'b1, 1'b0, 1'b1, 5'd10, 1'b1);
    chk("restart_hp1", dut.hp1_q, 100);
    chk("restart_hp2", dut.hp2_q, 100);
    chk("restart_wind", dut.wind_q, 0);
    chk("restart_lfsr", dut.lfsr, 16'hACE1);

    // Asynchronous reset mid-frame
    drive(1'b0, 1'b1, 1'b0, 5'd5, 1'b1);
    frame();
    chk("pre_rst_disp_hp1", hp_player1, 95);
    chk("pre_rst_disp_wind", wind, 3'b011);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_hp1", hp_player1, 100);
    chk("async_rst_wind", wind, 0);
    chk("async_rst_state", dut.state_q, 0);
    chk("async_rst_lfsr", dut.lfsr, 16'hACE1);
    step();
    rst_n = 1'b1;
    step();
    drive(1'b0, 1'b1, 1'b0, 5'd10, 1'b0);
    chk("post_rst_idle_hit", dut.hp1_q, 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hp_wind_ctl.md
# hp_wind_ctl

Game-state controller that owns both players' hit points and the current wind value, and feeds the HP/wind overlay drawing stage directly downstream. Hit events decrement HP with saturation at zero, and turn ends draw a new wind value from an LFSR. A three-state FSM tracks idle/play/game-over. Values presented to the drawing stage are latched once per frame, at the start of vertical blank, so the overlay never changes mid-frame.

## Interface
Parameters:
- `HP_MAX`, default 100: starting HP per player. Must be ≤ 127.
- `LFSR_SEED`, default 16'hACE1: wind LFSR value after reset and after `new_game`. Must be non-zero.

Ports:
- `clk60MHz`  in  1: system clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `vblnk`  in  1: vertical blank from the VGA timing chain, same clock domain.
- `new_game`  in  1: single-cycle pulse; start or restart the game.
- `hit_p1`  in  1: single-cycle pulse; player 1 takes damage.
- `hit_p2`  in  1: single-cycle pulse; player 2 takes damage.
- `dmg`  in  5: damage amount, 0..31. Shared by both hit inputs and sampled with them.
- `turn_end`  in  1: single-cycle pulse; step the LFSR and update the wind.
- `hp_player1`  out  7: frame-latched HP of player 1.
- `hp_player2`  out  7: frame-latched HP of player 2.
- `wind`  out  3: frame-latched wind. Bit 2 is direction (0 = right, 1 = left); bits [1:0] are magnitude.
- `game_over`  out  1: high in state OVER (not frame-latched).
- `winner`  out  2: 00 = none, 01 = player 1, 10 = player 2, 11 = draw. Valid while `game_over` is high.

## Operation
- FSM states:
  - IDLE (reset state): `new_game` → PLAY.
  - PLAY: either internal HP reaching 0 → OVER; `new_game` → PLAY with a full reinitialisation.
  - OVER: `new_game` → PLAY.
- Entering PLAY via `new_game`:
  - internal HP of both players = `HP_MAX`;
  - LFSR = `LFSR_SEED`;
  - internal wind = 3'b000.
- Hits are honoured only in PLAY:
  - `hit_p1`: hp1_int = (hp1_int > dmg) ? hp1_int − dmg : 0.
  - `hit_p2`: the same for hp2_int.
  - Compute the subtraction with one extra bit; no wrap-around.
- Simultaneous hits: `hit_p1` and `hit_p2` in the same cycle are both applied. If both HPs reach 0 in that cycle, `winner` = 11.
- Winner when only one HP reaches 0: the survivor wins (hp2 = 0 → 01; hp1 = 0 → 10).
- `dmg` = 0 with a hit pulse: no HP change and no state change.
- `turn_end` in PLAY:
  - LFSR steps once, Fibonacci form: fb = l[15]^l[13]^l[12]^l[10], l_next = {l[14:0], fb}.
  - New internal wind = l_next[2:0]. The value 3'b100 (negative zero) is normalised to 3'b000.
  - `turn_end` outside PLAY is ignored.
- `turn_end` coinciding with a hit: both are applied in the same cycle.
- `new_game` priority: it wins over `hit_*` and `turn_end` in the same cycle.
- Frame latch:
  - vblnk_q is `vblnk` registered; frame_start = vblnk & ~vblnk_q.
  - On frame_start, `hp_player1`, `hp_player2` and `wind` load the internal values (including any internal update made in that same cycle? No: they load the values registered before that edge).
- Reset values:
  - FSM = IDLE.
  - Internal HP = `HP_MAX`; outputs `hp_player1` / `hp_player2` = `HP_MAX`.
  - Internal and output wind = 0.
  - LFSR = `LFSR_SEED`.
  - vblnk_q = 0, `game_over` = 0, `winner` = 00.
- Reset asserted mid-game forces the reset values asynchronously. Play resumes only after a `new_game` pulse.

## Timing
- Internal HP, wind and FSM update on the clock edge that samples the pulse; `game_over` and `winner` are visible 1 cycle after the fatal hit.
- Display outputs change only on the edge at which frame_start = 1, i.e. 1 cycle after the `vblnk` rising edge reaches the block. Worst-case lag from event to display is one frame plus 1 cycle.
- Events arriving in the frame_start cycle are shown at the next frame.
- `game_over` is not frame-latched. The HP shown on screen may be non-zero until the next frame_start.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- `variable_pkg` holds:
  - `HP_MAX_DEF` and `WIND_SEED_DEF` constants;
  - `state_t` enum {IDLE, PLAY, OVER};
  - `winner_t` enum {NONE, P1, P2, DRAW}.
- Sub-module `wind_lfsr`:
  - ports: `clk60MHz`, `rst_n`, `load`, `seed`, `step`, `lfsr`[15:0];
  - performs the seed load and the step only.
- Wind normalisation, HP arithmetic, FSM and frame latch live in `hp_wind_ctl`.

## Test plan
- **Reset:** assert `rst_n` = 0, then release.
  - Outputs: hp 100/100, wind 0, `game_over` 0, state IDLE.
  - `hit_p1` with `dmg` = 10 while in IDLE → no change.
- **Saturation and win:** `new_game`, then `hit_p1` `dmg` = 31 four times.
  - Internal hp1 goes 69, 38, 7, 0.
  - `game_over` = 1 one cycle after the fourth hit; `winner` = 10.
  - After the next `vblnk` rise, `hp_player1` = 0.
- **Draw:** `new_game`, then hit both players to hp 5 each. Then `hit_p1` and `hit_p2` together with `dmg` = 20 → `winner` = 11, both HPs 0.
- **Wind:** `new_game`, then `turn_end`.
  - LFSR = 16'h59C3, internal wind = 3'b011.
  - `wind` output stays 0 until the next `vblnk` rise, then becomes 3'b011.
  - Check against a reference LFSR model over 200 turns, including the normalisation 3'b100 → 3'b000.
- **Frame latch:** issue a hit 1 cycle before a `vblnk` rise and another in the frame_start cycle.
  - The first hit appears at this frame.
  - The second appears only at the next `vblnk` rise.
- **Restart and reset mid-game:**
  - In PLAY, `new_game` together with `hit_p2` → hp 100/100, hit discarded.
  - Assert `rst_n` mid-frame → outputs return to reset values immediately, without waiting for a clock edge.
